// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner and next-PC sequencer.
// Selects sequential, branch, jump or jr targets with flush/stall/fault.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   stall           : hold pc/state/counter, control inputs ignored
//   branch_eq/_ne   : beq/bne in current instruction
//   zero            : ALU zero flag
//   jump, jump_reg  : j/jal and jr in current instruction
//   imm16           : signed branch offset in words
//   jtarget         : jump target field in words
//   rs_data         : jr target register value
//   pc, pc_plus4    : fetch address and pc + 4
//   fetch_valid     : pc is a valid fetch address
//   flush           : squash instruction fetched last cycle
//   fault, bad_addr : sticky misaligned-jr flag and captured address
//   redirect_count  : saturating count of taken redirects

module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_PC   = 32'h8000_0180,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_eq,
  input  logic             branch_ne,
  input  logic             zero,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic [15:0]      imm16,
  input  logic [25:0]      jtarget,
  input  logic [31:0]      rs_data,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             flush,
  output logic             fault,
  output logic [31:0]      bad_addr,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nx;
  logic [31:0]      pc_nx;
  logic             flush_nx;
  logic             fault_nx;
  logic [31:0]      bad_nx;
  logic [CNT_W-1:0] cnt_nx;

  logic        taken;
  logic        misaligned;
  logic        redirect;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] tgt;

  assign pc_plus4    = pc + 32'd4;
  assign fetch_valid = (state != BOOT);

  assign taken = (branch_eq & zero)
               | (branch_ne & ~zero);

  // Word offset to byte offset, sign extended.
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_tgt = pc_plus4 + br_off;
  assign j_tgt  = {pc_plus4[31:28], jtarget, 2'b00};

  assign misaligned = (rs_data[1:0] != 2'b00);
  assign jr_tgt     = misaligned ? EXC_PC : rs_data;

  assign redirect = jump_reg | jump | taken;

  always_comb begin
    tgt = pc_plus4;
    if (jump_reg)
      tgt = jr_tgt;
    else if (jump)
      tgt = j_tgt;
    else if (taken)
      tgt = br_tgt;
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    flush_nx = 1'b0;
    fault_nx = fault;
    bad_nx   = bad_addr;
    cnt_nx   = redirect_count;
    unique case (state)
      BOOT: begin
        state_nx = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (redirect) begin
            pc_nx    = tgt;
            state_nx = FLUSH;
            flush_nx = 1'b1;
            if (redirect_count != CNT_MAX)
              cnt_nx = redirect_count + CNT_ONE;
            if (jump_reg && misaligned) begin
              fault_nx = 1'b1;
              // Keep the first offending address only.
              if (!fault)
                bad_nx = rs_data;
            end
          end else begin
            pc_nx = pc_plus4;
          end
        end
      end
      FLUSH: begin
        // Controls here belong to the squashed
        // instruction, so they are ignored.
        if (!stall) begin
          pc_nx    = pc_plus4;
          state_nx = RUN;
        end
      end
      default: begin
        state_nx = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      flush          <= 1'b0;
      fault          <= 1'b0;
      bad_addr       <= 32'd0;
      redirect_count <= '0;
    end else begin
      state          <= state_nx;
      pc             <= pc_nx;
      flush          <= flush_nx;
      fault          <= fault_nx;
      bad_addr       <= bad_nx;
      redirect_count <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random checks of pc_sequencer
// against a behavioural next-PC model.

module tb_pc_sequencer;

  localparam logic [31:0] EXC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_eq;
  logic        branch_ne;
  logic        zero;
  logic        jump;
  logic        jump_reg;
  logic [15:0] imm16;
  logic [25:0] jtarget;
  logic [31:0] rs_data;

  logic [31:0] pc, pc_plus4, bad_addr;
  logic        fetch_valid, flush, fault;
  logic [15:0] redirect_count;

  logic [31:0] pc_b, pc_plus4_b, bad_addr_b;
  logic        fetch_valid_b, flush_b, fault_b;
  logic [1:0]  redirect_count_b;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] m_pc;
  logic [31:0] m_bad;
  bit          m_boot;
  bit          m_squash;
  bit          m_flush;
  bit          m_fault;
  int          m_cnt;
  int          m_cnt2;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_eq(branch_eq), .branch_ne(branch_ne),
    .zero(zero), .jump(jump), .jump_reg(jump_reg),
    .imm16(imm16), .jtarget(jtarget), .rs_data(rs_data),
    .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .flush(flush),
    .fault(fault), .bad_addr(bad_addr),
    .redirect_count(redirect_count)
  );

  pc_sequencer #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_eq(branch_eq), .branch_ne(branch_ne),
    .zero(zero), .jump(jump), .jump_reg(jump_reg),
    .imm16(imm16), .jtarget(jtarget), .rs_data(rs_data),
    .pc(pc_b), .pc_plus4(pc_plus4_b),
    .fetch_valid(fetch_valid_b), .flush(flush_b),
    .fault(fault_b), .bad_addr(bad_addr_b),
    .redirect_count(redirect_count_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    reset     = 1'b0;
    stall     = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    zero      = 1'b0;
    jump      = 1'b0;
    jump_reg  = 1'b0;
    imm16     = '0;
    jtarget   = '0;
    rs_data   = '0;
  endtask

  // Next-PC rules applied to the inputs seen at the edge.
  task automatic model();
    logic [31:0] p4;
    logic [31:0] tgt;
    bit          redir;
    bit          tk;
    p4 = m_pc + 32'd4;
    if (reset) begin
      m_pc = 32'h0; m_boot = 1; m_squash = 0;
      m_flush = 0; m_fault = 0; m_bad = 0;
      m_cnt = 0; m_cnt2 = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (stall) begin
      m_flush = 0;
    end else if (m_squash) begin
      m_pc = p4; m_squash = 0; m_flush = 0;
    end else begin
      tk = (branch_eq && zero) || (branch_ne && !zero);
      redir = 1;
      if (jump_reg) begin
        if (rs_data % 4 != 0) begin
          tgt = EXC;
          if (!m_fault) m_bad = rs_data;
          m_fault = 1;
        end else begin
          tgt = rs_data;
        end
      end else if (jump) begin
        tgt = (p4 & 32'hF000_0000)
            | (32'(jtarget) * 4);
      end else if (tk) begin
        tgt = p4 + 32'(32'(signed'(imm16)) * 4);
      end else begin
        redir = 0;
        tgt = p4;
      end
      m_pc = tgt;
      m_flush = redir;
      m_squash = redir;
      if (redir) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  task automatic compare();
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("fetch_valid", 32'(fetch_valid), 32'(!m_boot));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("bad_addr", bad_addr, m_bad);
    chk("count", 32'(redirect_count), m_cnt);
    chk("count_w2", 32'(redirect_count_b), m_cnt2);
    chk("pc_w2", pc_b, m_pc);
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    compare();
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    clr();
    m_pc = 0; m_bad = 0; m_boot = 1;
    m_squash = 0; m_flush = 0; m_fault = 0;
    m_cnt = 0; m_cnt2 = 0;
    #1;

    // Reset release and boot cycle
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 32'h0);
    tick();
    chk("boot_fv", 32'(fetch_valid), 32'h1);
    chk("boot_pc", pc, 32'h0);
    tick(); chk("seq_4", pc, 32'h4);
    tick(); chk("seq_8", pc, 32'h8);
    tick(); chk("seq_c", pc, 32'hC);

    // Walk to 0x100 then beq taken / not taken
    for (int i = 0; i < 61; i++) tick();
    chk("at_100", pc, 32'h100);
    branch_eq = 1; zero = 1; imm16 = 16'hFFFE;
    tick();
    chk("beq_pc", pc, 32'hFC);
    chk("beq_flush", 32'(flush), 32'h1);
    chk("beq_cnt", 32'(redirect_count), 32'h1);
    clr();
    tick();
    chk("beq_fl_pc", pc, 32'h100);
    chk("beq_fl_flush", 32'(flush), 32'h0);
    branch_eq = 1; zero = 0; imm16 = 16'hFFFE;
    tick();
    chk("beq_nt_pc", pc, 32'h104);
    chk("beq_nt_flush", 32'(flush), 32'h0);

    // Jump beats branch, and is ignored in FLUSH
    clr();
    jump_reg = 1; rs_data = 32'hA000_000C;
    tick();
    clr();
    tick();
    chk("at_a10", pc, 32'hA000_0010);
    jump = 1; jtarget = 26'h40;
    branch_eq = 1; zero = 1; imm16 = 16'h0010;
    tick();
    chk("jmp_pc", pc, 32'hA000_0100);
    branch_eq = 0;
    tick();
    chk("jmp_sq_pc", pc, 32'hA000_0104);

    // Misaligned jr and sticky fault
    clr();
    jump_reg = 1; rs_data = 32'h0040_0002;
    tick();
    chk("jr_exc_pc", pc, EXC);
    chk("jr_fault", 32'(fault), 32'h1);
    chk("jr_bad", bad_addr, 32'h0040_0002);
    clr();
    tick();
    jump_reg = 1; rs_data = 32'h3;
    tick();
    chk("jr2_pc", pc, EXC);
    chk("jr2_bad", bad_addr, 32'h0040_0002);
    do_reset();
    chk("rst_fault", 32'(fault), 32'h0);
    tick();

    // Stall holds everything and drops flush
    stall = 1; jump = 1; jtarget = 26'h123;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 32'h0);
      chk("stall_flush", 32'(flush), 32'h0);
      chk("stall_cnt", 32'(redirect_count), 32'h0);
    end
    stall = 0;
    tick();
    chk("unstall_pc", pc, 32'h0000_048C);
    chk("unstall_cnt", 32'(redirect_count), 32'h1);
    stall = 1;
    tick();
    chk("fl_stall_flush", 32'(flush), 32'h0);
    stall = 0;
    tick();
    chk("fl_after_stall_pc", pc, 32'h0000_0490);

    // pc wrap through 0xFFFF_FFFC
    clr();
    jump_reg = 1; rs_data = 32'hFFFF_FFFC;
    tick();
    chk("at_top", pc, 32'hFFFF_FFFC);
    chk("top_p4", pc_plus4, 32'h0);
    clr();
    tick();
    chk("wrap_pc", pc, 32'h0);
    tick();
    chk("wrap_seq", pc, 32'h4);

    // Counter saturation on the 2-bit instance
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      jump = 1; jtarget = 26'(i * 16);
      tick();
      clr();
      tick();
    end
    chk("sat_w2", 32'(redirect_count_b), 32'h3);
    chk("sat_w16", 32'(redirect_count), 32'h5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      stall     = ($urandom_range(0, 7) == 0);
      branch_eq = ($urandom_range(0, 5) == 0);
      branch_ne = ($urandom_range(0, 5) == 0);
      zero      = 1'($urandom);
      jump      = ($urandom_range(0, 9) == 0);
      jump_reg  = ($urandom_range(0, 11) == 0);
      imm16     = 16'($urandom);
      jtarget   = 26'($urandom);
      rs_data   = $urandom;
      if ($urandom_range(0, 3) != 0)
        rs_data[1:0] = 2'b00;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter and sequences next-PC selection for the single-cycle/multicycle MIPS core: sequential (PC+4), conditional branch (PC+4 + sext(imm16)<<2), jump ({PC+4[31:28], target26, 2'b00}) and jump-register. Implements its own word-offset shift-by-2 internally. Generates a one-cycle fetch flush after each redirect, supports stall, traps misaligned jr targets to an exception vector and keeps a saturating redirect counter for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_PC, 32'h8000_0180, PC loaded on misaligned jump-register target
CNT_W, 16, width of redirect counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC; all control inputs ignored while high
branch_eq  input  1  current instruction is beq
branch_ne  input  1  current instruction is bne
zero  input  1  ALU zero flag for current instruction
jump  input  1  current instruction is j/jal
jump_reg  input  1  current instruction is jr
imm16  input  16  branch offset (word units, signed)
jtarget  input  26  jump target field (word units)
rs_data  input  32  register value for jr
pc  output  32  current fetch address (registered)
pc_plus4  output  32  pc + 4, combinational from pc
fetch_valid  output  1  pc is a valid fetch address this cycle
flush  output  1  discard instruction fetched in previous cycle
fault  output  1  sticky misaligned-jr flag
bad_addr  output  32  rs_data captured at fault
redirect_count  output  CNT_W  number of taken redirects, saturating

Behaviour:
- Reset (sampled at edge, overrides everything, including mid-stall/mid-flush): pc=RESET_PC, state=BOOT, fetch_valid=0, flush=0, fault=0, bad_addr=0, redirect_count=0.
- States: BOOT, RUN, FLUSH.
- BOOT: one cycle, fetch_valid=0, pc held; -> RUN unconditionally (stall ignored in BOOT).
- RUN/FLUSH: fetch_valid=1. If stall=1: pc, state, counter unchanged; flush output drops to 0 (flush is never extended by stall).
- If stall=0, next-PC priority: jump_reg > jump > taken branch > sequential.
- Taken branch = (branch_eq & zero) | (branch_ne & ~zero).
- Branch target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}, modulo 2^32 (wrap, no overflow flag).
- Jump target = {pc_plus4[31:28], jtarget, 2'b00}.
- jr: if rs_data[1:0]==0, target=rs_data; else target=EXC_PC, fault<=1, bad_addr<=rs_data (only first fault captures bad_addr; fault stays set until reset).
- Sequential: pc<=pc_plus4 (0xFFFF_FFFC wraps to 0), state<=RUN, flush<=0.
- Any redirect (jr, jump, taken branch, including fault vector): pc<=target, state<=FLUSH, flush<=1 for exactly the following cycle, redirect_count<=redirect_count+1 saturating at all-ones.
- Redirect while in FLUSH: inputs in the FLUSH cycle belong to the squashed instruction -> ignored; pc<=pc_plus4, -> RUN. Hence back-to-back redirects impossible.
- Redirect whose target equals pc_plus4 still counts as redirect and flushes.
- Multiple control inputs high simultaneously: resolved by priority above, no error.
- pc_plus4 = pc + 4 combinational, zero latency; pc latency to redirect = 1 cycle.

Test Plan:
- Reset release: reset high 2 cycles then low -> cycle 1 pc=0x0, fetch_valid=0; cycle 2 fetch_valid=1; subsequent cycles pc=0x4, 0x8, 0xC.
- beq taken: pc=0x100, branch_eq=1, zero=1, imm16=0xFFFE -> next pc=0xFC, flush=1 one cycle, redirect_count=1; same with zero=0 -> pc=0x104, flush=0.
- Jump + priority: pc=0xA000_0010, jump=1, jtarget=0x0000040, branch_eq=1, zero=1 -> pc=0xA000_0100; next cycle (FLUSH) jump=1 again -> ignored, pc=0xA000_0104.
- Misaligned jr: rs_data=0x0040_0002, jump_reg=1 -> pc=0x8000_0180, fault=1, bad_addr=0x0040_0002; later misaligned jr with 0x3 -> bad_addr unchanged; reset clears fault.
- Stall: stall=1 for 3 cycles with jump=1 asserted -> pc held, flush=0, count unchanged; stall=0 with jump=1 -> redirect taken.
- Wrap/saturation: pc=0xFFFF_FFFC sequential -> 0x0; force CNT_W=2, 5 redirects -> redirect_count=3.
